// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC sine sample source.
//   ATAN     : micro-rotation angles in binary-angle units (2^16 = 2*pi)
//   X0_INIT  : pre-scaled start vector, cancels CORDIC gain, output * 16
//   OUT_MAX  : largest sample magnitude ever emitted
//   state_e  : sequencing states of the iterative engine
package cordic_pkg;

  localparam int CW      = 14;
  localparam int PHASE_W = 16;
  localparam int X0_INIT = 1234;
  localparam int OUT_MAX = 127;

  // Entry 0 sits in the least significant slice.
  localparam logic [11:0][15:0] ATAN = {
    16'd5,   16'd10,  16'd20,   16'd41,   16'd81,   16'd163,
    16'd326, 16'd651, 16'd1297, 16'd2555, 16'd4836, 16'd8192
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_rot_step.sv
// cordic_rot_step: one combinational CORDIC micro-rotation in rotation mode.
//   x_i, y_i : current vector (signed, CW bits)
//   z_i      : residual angle (signed, ZW bits)
//   iter_i   : iteration index, selects shift amount and ATAN entry
//   x_o, y_o, z_o : vector and residual angle after the rotation
module cordic_rot_step
  import cordic_pkg::*;
#(
  parameter int CW = 14,
  parameter int ZW = 17
) (
  input  logic signed [CW-1:0] x_i,
  input  logic signed [CW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [3:0]    iter_i,
  output logic signed [CW-1:0] x_o,
  output logic signed [CW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [CW-1:0] xs_s;
  logic signed [CW-1:0] ys_s;
  logic signed [ZW-1:0] atan_s;

  // Scaled cross terms and the angle for this step; indices past the table yield zero.
  always_comb begin
    xs_s = x_i >>> iter_i;
    ys_s = y_i >>> iter_i;
    if (iter_i < 4'd12) begin
      atan_s = $signed({{(ZW-16){1'b0}}, ATAN[iter_i]});
    end else begin
      atan_s = '0;
    end
  end

  // Rotate toward zero residual angle; z >= 0 means a positive rotation.
  always_comb begin
    if (!z_i[ZW-1]) begin
      x_o = x_i - ys_s;
      y_o = y_i + xs_s;
      z_o = z_i - atan_s;
    end else begin
      x_o = x_i + ys_s;
      y_o = y_i - xs_s;
      z_o = z_i + atan_s;
    end
  end

endmodule

// File: rtl/cordic_sine_gen.sv
// cordic_sine_gen: phase-accumulator sine source with an iterative CORDIC.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : enables sample ticks (divider held at zero when low)
//   ftw          : phase increment applied on each accepted tick
//   sample_div   : tick period is sample_div+1 clocks
//   sample       : signed sine sample in -127..+127, held between updates
//   sample_valid : one-cycle pulse when sample updates
//   busy         : engine is loading, rotating or emitting
//   overrun      : sticky flag, a tick arrived while busy; cleared by en=0
module cordic_sine_gen #(
  parameter int ITER    = 10,
  parameter int CW      = cordic_pkg::CW,
  parameter int PHASE_W = cordic_pkg::PHASE_W,
  parameter int DIV_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PHASE_W-1:0]  ftw,
  input  logic [DIV_W-1:0]    sample_div,
  output logic signed [7:0]   sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  import cordic_pkg::*;

  // One extra bit keeps the folded angle and its residual free of overflow.
  localparam int ZW = PHASE_W + 1;
  localparam logic [3:0]           ITER_LAST = 4'(ITER - 1);
  localparam logic signed [CW-1:0] X0        = CW'(X0_INIT);
  localparam logic signed [CW:0]   R_MAX     = (CW+1)'(OUT_MAX);
  localparam logic signed [CW:0]   R_MIN     = -R_MAX;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   phase_lat_q, phase_lat_d;
  logic [3:0]           iter_q, iter_d;
  logic signed [CW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic                 neg_q, neg_d;
  logic signed [7:0]    sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                 tick_s;
  logic                 fold_neg_s;
  logic [PHASE_W-1:0]   fold_s;
  logic signed [ZW-1:0] z0_s;
  logic signed [CW-1:0] x_nx_s, y_nx_s;
  logic signed [ZW-1:0] z_nx_s;
  logic signed [CW:0]   rnd_s;
  logic signed [7:0]    r_s;
  logic signed [7:0]    out_s;

  cordic_rot_step #(.CW(CW), .ZW(ZW)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .iter_i (iter_q),
    .x_o    (x_nx_s),
    .y_o    (y_nx_s),
    .z_o    (z_nx_s)
  );

  // Sample-rate divider; >= keeps it bounded if sample_div shrinks mid-count.
  always_comb begin
    tick_s = 1'b0;
    div_d  = div_q;
    if (!en) begin
      div_d = '0;
    end else if (div_q >= sample_div) begin
      tick_s = 1'b1;
      div_d  = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Fold quadrants 1 and 2 onto 3 and 0 via sin(theta+pi) = -sin(theta).
  always_comb begin
    fold_neg_s = phase_lat_q[PHASE_W-1] ^ phase_lat_q[PHASE_W-2];
    if (fold_neg_s) begin
      fold_s = phase_lat_q ^ {1'b1, {(PHASE_W-1){1'b0}}};
    end else begin
      fold_s = phase_lat_q;
    end
    z0_s = $signed({fold_s[PHASE_W-1], fold_s});
  end

  // Drop the 4 fractional bits with rounding, clamp, then undo the fold.
  always_comb begin
    rnd_s = $signed({y_q[CW-1], y_q} + {{(CW-3){1'b0}}, 4'b1000}) >>> 4;
    if (rnd_s > R_MAX) begin
      r_s = R_MAX[7:0];
    end else if (rnd_s < R_MIN) begin
      r_s = R_MIN[7:0];
    end else begin
      r_s = rnd_s[7:0];
    end
    if (neg_q) begin
      out_s = -r_s;
    end else begin
      out_s = r_s;
    end
  end

  // Engine sequencing: accept a tick only in IDLE, then load, rotate, emit.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    phase_lat_d = phase_lat_q;
    iter_d      = iter_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    neg_d       = neg_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          phase_lat_d = phase_q;
          phase_d     = phase_q + ftw;
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        x_d     = X0;
        y_d     = '0;
        z_d     = z0_s;
        neg_d   = fold_neg_s;
        iter_d  = 4'd0;
        state_d = ROT;
      end
      ROT: begin
        x_d    = x_nx_s;
        y_d    = y_nx_s;
        z_d    = z_nx_s;
        iter_d = iter_q + 4'd1;
        if (iter_q == ITER_LAST) begin
          state_d = OUT;
        end else begin
          state_d = ROT;
        end
      end
      OUT: begin
        sample_d = out_s;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overrun and registered busy flag.
  always_comb begin
    if (!en) begin
      overrun_d = 1'b0;
    end else if (tick_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      phase_q     <= '0;
      phase_lat_q <= '0;
      iter_q      <= 4'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      neg_q       <= 1'b0;
      sample_q    <= 8'sd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      phase_lat_q <= phase_lat_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cordic_sine_gen.sv
module tb_cordic_sine_gen;

  localparam int ITER = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [15:0]       ftw;
  logic [15:0]       sample_div;
  logic signed [7:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int samp  [4096];
  int stamp [4096];
  int atan_t [12] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5};

  cordic_sine_gen #(.ITER(ITER)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ftw          (ftw),
    .sample_div   (sample_div),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Algorithm-level CORDIC on the folded angle, using plain integers.
  function automatic int model_sample(input int ph);
    int x, y, z, xn, d, r, q;
    bit neg;
    q   = (ph >> 14) & 3;
    neg = (q == 1) || (q == 2);
    z   = neg ? (ph ^ 32'h8000) : ph;
    if (z >= 32768) z = z - 65536;
    x = 1234;
    y = 0;
    for (int i = 0; i < ITER; i++) begin
      d  = (z >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      y  = y + d * (x >>> i);
      x  = xn;
      z  = z - d * atan_t[i];
    end
    r = (y + 8) >>> 4;
    if (r > 127) r = 127;
    if (r < -127) r = -127;
    return neg ? -r : r;
  endfunction

  // Ideal sine scaled to the output range, rounded to nearest.
  function automatic int sin_ref(input int ph);
    real v;
    v = 127.0 * $sin(2.0 * 3.14159265358979 * ph / 65536.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Records up to n sample updates with their cycle stamps, within budget cycles.
  task automatic wait_samples(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(posedge clk);
      #1;
      if (sample_valid === 1'b1) begin
        samp[got]  = sample;
        stamp[got] = cyc;
        got++;
      end
    end
  endtask

  task automatic test_reset();
    int got;
    en = 1'b1;
    ftw = 16'($urandom_range(1, 65535));
    sample_div = 16'(ITER + 2);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (sample !== 8'sd0) begin errors++; $display("FAIL reset_sample got %0d expected 0", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun); end
    rst_n = 1'b1;
    wait_samples(1, 80, got);
    checks++; if (got != 1) begin errors++; $display("FAIL reset_first_timeout got %0d samples expected 1", got); end
    checks++; if (got == 1 && samp[0] != 0) begin errors++; $display("FAIL reset_first_sample got %0d expected 0", samp[0]); end
    en = 1'b0;
  endtask

  task automatic test_quadrants();
    int got, start, ph, tgt, last;
    int tq [4] = '{0, 127, 0, -127};
    do_reset();
    ftw = 16'h4000;
    sample_div = 16'd15;
    en = 1'b1;
    start = cyc;
    wait_samples(9, 9 * 16 + 40, got);
    checks++; if (got != 9) begin errors++; $display("FAIL quad_timeout got %0d samples expected 9", got); end
    checks++; if (stamp[0] - start != 16 + ITER + 2) begin errors++; $display("FAIL quad_latency got %0d expected %0d", stamp[0] - start, 16 + ITER + 2); end
    for (int k = 0; k < got; k++) begin
      ph  = (k * 16'h4000) % 65536;
      tgt = tq[k % 4];
      checks++; if (samp[k] - tgt > 1 || tgt - samp[k] > 1) begin errors++; $display("FAIL quad_value k=%0d got %0d expected %0d+-1", k, samp[k], tgt); end
      checks++; if (samp[k] != model_sample(ph)) begin errors++; $display("FAIL quad_model k=%0d got %0d expected %0d", k, samp[k], model_sample(ph)); end
      if (k > 0) begin
        checks++; if (stamp[k] - stamp[k-1] != 16) begin errors++; $display("FAIL quad_spacing k=%0d got %0d expected 16", k, stamp[k] - stamp[k-1]); end
      end
    end
    last = samp[8];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++; if (sample !== 8'(last)) begin errors++; $display("FAIL quad_hold c=%0d got %0d expected %0d", c, sample, last); end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    int got, ph, ref_v;
    do_reset();
    ftw = 16'hF000;
    sample_div = 16'd15;
    en = 1'b1;
    wait_samples(8, 8 * 16 + 40, got);
    checks++; if (got != 8) begin errors++; $display("FAIL wrap_timeout got %0d samples expected 8", got); end
    for (int k = 0; k < got; k++) begin
      ph    = (k * 16'hF000) % 65536;
      ref_v = sin_ref(ph);
      checks++; if (samp[k] - ref_v > 2 || ref_v - samp[k] > 2) begin errors++; $display("FAIL wrap_accuracy k=%0d got %0d expected %0d+-2", k, samp[k], ref_v); end
      checks++; if (samp[k] != model_sample(ph)) begin errors++; $display("FAIL wrap_model k=%0d got %0d expected %0d", k, samp[k], model_sample(ph)); end
      if (k >= 1 && k <= 4) begin
        checks++; if (!(samp[k] < samp[k-1] && samp[k] < 0)) begin errors++; $display("FAIL wrap_decreasing k=%0d got %0d previous %0d expected lower and negative", k, samp[k], samp[k-1]); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_overrun();
    int got, f, per, sp;
    do_reset();
    f = $urandom_range(1, 65535);
    ftw = 16'(f);
    sample_div = 16'd3;
    per = 4;
    sp  = ((ITER + 3 + per - 1) / per) * per;
    en = 1'b1;
    wait_samples(5, 200, got);
    checks++; if (got != 5) begin errors++; $display("FAIL ovr_timeout got %0d samples expected 5", got); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b expected 1", overrun); end
    for (int k = 0; k < got; k++) begin
      checks++; if (samp[k] != model_sample((k * f) % 65536)) begin errors++; $display("FAIL ovr_model k=%0d got %0d expected %0d", k, samp[k], model_sample((k * f) % 65536)); end
      if (k > 0) begin
        checks++; if (stamp[k] - stamp[k-1] != sp) begin errors++; $display("FAIL ovr_spacing k=%0d got %0d expected %0d", k, stamp[k] - stamp[k-1], sp); end
      end
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", overrun); end
    en = 1'b1;
    wait_samples(1, 40, got);
    checks++; if (got != 1) begin errors++; $display("FAIL ovr_resume_timeout got %0d samples expected 1", got); end
    checks++; if (got == 1 && samp[0] != model_sample((5 * f) % 65536)) begin errors++; $display("FAIL ovr_resume_phase got %0d expected %0d", samp[0], model_sample((5 * f) % 65536)); end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    int got, nvalid;
    bit seen;
    do_reset();
    ftw = 16'h2000;
    sample_div = 16'd40;
    en = 1'b1;
    wait_samples(2, 140, got);
    checks++; if (got != 2 || samp[1] != model_sample(16'h2000)) begin errors++; $display("FAIL arst_pre got %0d samples last %0d expected 2 samples last %0d", got, samp[1], model_sample(16'h2000)); end
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst_busy_timeout got busy=%b expected 1", busy); end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sample !== 8'sd0) begin errors++; $display("FAIL arst_sample got %0d expected 0", sample); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", busy); end
    checks++; if (sample_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL arst_flags got valid=%b overrun=%b expected 0 0", sample_valid, overrun); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (sample_valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL arst_no_valid got %0d pulses expected 0", nvalid); end
    en = 1'b0;
  endtask

  task automatic test_accuracy(input int f, input int n);
    int got, ph, ref_v;
    do_reset();
    ftw = 16'(f);
    sample_div = 16'(ITER + 2);
    en = 1'b1;
    wait_samples(n, n * (ITER + 3) + 60, got);
    checks++; if (got != n) begin errors++; $display("FAIL acc_timeout ftw=%0d got %0d samples expected %0d", f, got, n); end
    for (int k = 0; k < got; k++) begin
      ph    = (k * f) % 65536;
      ref_v = sin_ref(ph);
      checks++; if (samp[k] - ref_v > 2 || ref_v - samp[k] > 2 || samp[k] == -128) begin errors++; $display("FAIL acc_sin phase=%0d got %0d expected %0d+-2", ph, samp[k], ref_v); end
      checks++; if (samp[k] != model_sample(ph)) begin errors++; $display("FAIL acc_model phase=%0d got %0d expected %0d", ph, samp[k], model_sample(ph)); end
      if (k > 0) begin
        checks++; if (stamp[k] - stamp[k-1] != ITER + 3) begin errors++; $display("FAIL acc_back_to_back k=%0d got %0d expected %0d", k, stamp[k] - stamp[k-1], ITER + 3); end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    ftw = 16'd0;
    sample_div = 16'd0;
    test_reset();
    test_quadrants();
    test_wrap();
    test_overrun();
    test_async_reset();
    test_accuracy(1, 500);
    test_accuracy(16'h4001, 500);
    test_accuracy($urandom_range(1, 65535) | 1, 2500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
